stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Run/stop/lap/clear sequencer for the stopwatch timing datapath.
//  Turns debounced push-button levels into one-cycle press events and runs a 4-state FSM.
//  Drives a prescaled count-enable into the BCD counter chain, built from JKFlipFlop cells.
//  Also drives clear and lap-snapshot strobes, and a display-hold flag for the display mux.
// PARAMETERS
//  CLK_DIV  500000  CLK cycles per count tick (50 MHz -> 100 Hz, 10 ms resolution); must be >= 2
//  DIV_W    19      prescaler counter width; must satisfy 2**DIV_W >= CLK_DIV
// PORTS
//  CLK        in   1   system clock; all logic rising-edge
//  rst        in   1   synchronous, active-high reset
//  btn_ss     in   1   start/stop button level (debounced, CLK-synchronous)
//  btn_lap    in   1   lap button level (debounced, CLK-synchronous)
//  btn_clr    in   1   clear button level (debounced, CLK-synchronous)
//  cnt_en     out  1   one-cycle count tick to the counter chain
//  cnt_clr    out  1   one-cycle clear strobe to the counter chain
//  lap_load   out  1   one-cycle strobe: display register captures the live count
//  disp_hold  out  1   1 = display shows lap register; 0 = display shows live count
//  running    out  1   1 while timing (RUN or LAP)
//  state      out  2   current FSM state (debug/LED)
// BEHAVIOUR
//  Reset (rst=1 at CLK edge):
//   - state=IDLE, prescaler=0.
//   - cnt_en, cnt_clr, lap_load, disp_hold and running are all 0.
//   - Button history registers are set to 1, so a button held through reset gives no press.
//   - It must be released and pressed again.
//  Press detect: press_x = btn_x & ~btn_x_q, one cycle per rising edge; holding a button gives exactly one press.
//  States: IDLE=2'b00, RUN=2'b01, STOP=2'b10, LAP=2'b11.
//   - IDLE: ss -> RUN. clr -> IDLE and pulse cnt_clr. lap ignored.
//   - RUN:  ss -> STOP. lap -> LAP and pulse lap_load. clr ignored.
//   - LAP:  lap -> RUN (display live again). ss -> STOP (hold released). clr ignored.
//   - STOP: ss -> RUN. clr -> IDLE, pulse cnt_clr, prescaler forced to 0. lap ignored.
//  Simultaneous presses: priority clr > ss > lap. Only one transition per cycle. Lower-priority presses in that cycle are discarded.
//  Latency: press seen in cycle n -> new state, cnt_clr and lap_load are all visible in cycle n+1.
//   - cnt_clr and lap_load are registered and last exactly one cycle.
//  disp_hold = (state==LAP). running = (state==RUN | state==LAP). Both are decoded from the state register.
//  Prescaler behaviour:
//   - Increments every cycle while running.
//   - At CLK_DIV-1 it wraps to 0, and cnt_en=1 in that same cycle.
//   - cnt_en is combinational: (prescaler==CLK_DIV-1) & running.
//   - In STOP the prescaler holds its value, so phase is kept across stop/start.
//   - It is zeroed only by rst or a clr press in STOP/IDLE.
//   - First tick after IDLE->RUN comes CLK_DIV cycles after RUN entry: cycle k+CLK_DIV-1, where k = first RUN cycle.
//  Tick on the exit cycle: if a tick coincides with a RUN->STOP press cycle, cnt_en still fires, because it uses the current state.
//  rst mid-operation overrides any press in the same cycle. No strobe is produced.
// STRUCTURE
//  stopwatch_pkg holds:
//   - state localparams ST_IDLE/ST_RUN/ST_STOP/ST_LAP and the 2-bit state width.
//   - the default CLK_DIV.
//  Sub-module tick_prescaler: parameters CLK_DIV and DIV_W; ports CLK, rst, en, clr, tick.
//  FSM, press detect and strobe registers stay in stopwatch_ctrl.
// TESTING (CLK_DIV=4, DIV_W=2)
//  1. Hold btn_ss=1 through 2 rst cycles, keep it 1 for 5 cycles -> state stays 00, all outputs 0. Release and repress -> state 01.
//  2. IDLE, one ss press -> state=01 next cycle; cnt_en at k+3, k+7, k+11, exactly 1 cycle wide each.
//  3. RUN for 6 cycles, press ss -> STOP, no cnt_en. Wait 20 cycles, press ss -> first cnt_en 2 cycles after RUN re-entry (phase kept).
//  4. RUN, lap press -> lap_load=1 for 1 cycle, disp_hold=1, state=11, cnt_en continues. Lap again -> state=01, disp_hold=0, no lap_load.
//  5. STOP, clr press -> cnt_clr=1 for 1 cycle, state=00, prescaler 0. clr in RUN -> no cnt_clr, state stays 01.
//  6. Simultaneous presses:
//   - STOP, ss+clr same cycle -> IDLE with cnt_clr.
//   - RUN, ss+lap same cycle -> STOP, no lap_load.
//   - LAP, assert rst with lap press -> IDLE, no strobes.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing constants for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned CLK_DIV_DEF = 500000;
  localparam int unsigned DIV_W_DEF   = 19;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] ST_STOP = 2'b10;
  localparam logic [STATE_W-1:0] ST_LAP  = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_STOP = ST_STOP,
    S_LAP  = ST_LAP
  } sw_state_e;

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Count-enable prescaler: one tick every CLK_DIV enabled cycles, phase held while disabled.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 500000,
  parameter int unsigned DIV_W   = 19
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Tick is taken from the current count so it fires on the wrap cycle itself.
  assign tick = en & (cnt == LAST);

  // Prescaler counter: wraps at LAST, holds when disabled, zeroed by clr.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/lap/clear sequencer with press detection and strobe generation.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DIV_W   = DIV_W_DEF
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               btn_ss,
  input  logic               btn_lap,
  input  logic               btn_clr,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               lap_load,
  output logic               disp_hold,
  output logic               running,
  output logic [STATE_W-1:0] state
);

  sw_state_e st, st_nxt;
  logic      ss_q, lap_q, clr_q;
  logic      press_ss, press_lap, press_clr;
  logic      cnt_clr_nxt, lap_load_nxt, presc_clr;

  assign press_ss  = btn_ss  & ~ss_q;
  assign press_lap = btn_lap & ~lap_q;
  assign press_clr = btn_clr & ~clr_q;

  assign state     = st;
  assign disp_hold = (st == S_LAP);
  assign running   = (st == S_RUN) | (st == S_LAP);

  // Button history; reset high so a button held through reset needs a fresh press.
  always_ff @(posedge CLK) begin
    if (rst) begin
      ss_q  <= 1'b1;
      lap_q <= 1'b1;
      clr_q <= 1'b1;
    end else begin
      ss_q  <= btn_ss;
      lap_q <= btn_lap;
      clr_q <= btn_clr;
    end
  end

  // State and strobe registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      st       <= S_IDLE;
      cnt_clr  <= 1'b0;
      lap_load <= 1'b0;
    end else begin
      st       <= st_nxt;
      cnt_clr  <= cnt_clr_nxt;
      lap_load <= lap_load_nxt;
    end
  end

  // Next-state and strobe decode; priority clr > ss > lap, one transition per cycle.
  always_comb begin
    st_nxt       = st;
    cnt_clr_nxt  = 1'b0;
    lap_load_nxt = 1'b0;
    presc_clr    = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (press_clr) begin
          cnt_clr_nxt = 1'b1;
          presc_clr   = 1'b1;
        end else if (press_ss) begin
          st_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (press_ss) begin
          st_nxt = S_STOP;
        end else if (press_lap) begin
          st_nxt       = S_LAP;
          lap_load_nxt = 1'b1;
        end
      end
      S_LAP: begin
        if (press_ss)       st_nxt = S_STOP;
        else if (press_lap) st_nxt = S_RUN;
      end
      S_STOP: begin
        if (press_clr) begin
          st_nxt      = S_IDLE;
          cnt_clr_nxt = 1'b1;
          presc_clr   = 1'b1;
        end else if (press_ss) begin
          st_nxt = S_RUN;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  tick_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_presc (
    .CLK  (CLK),
    .rst  (rst),
    .en   (running),
    .clr  (presc_clr),
    .tick (cnt_en)
  );

endmodule
